bin2bcd_seq: RTL and testbench

//  Sequential signed-binary to packed-BCD converter using shift-add-3 (double dabble), one bit per clock.

---
 rtl/bin2bcd_seq.sv | 108 ++++++++++
 tb/tb_bin2bcd_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential signed-binary to packed-BCD converter (double dabble, one bit
// per clock). Emits the magnitude as BCD digits plus a separate sign flag
// for the seven-segment encoder chain.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negr_q, negr_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic            done_q, done_d;
  logic [BW-1:0]   adj;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;

  // Add-3 correction: every digit >= 5 is bumped so the following shift
  // carries correctly into the next decimal digit.
  always_comb begin
    adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
  end

  // Next-state and datapath control; published outputs only move at FINISH.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    negr_d  = negr_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Magnitude is taken as unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
          negr_d  = din[WIDTH-1];
          mag_d   = din[WIDTH-1] ? (~din + WIDTH'(1)) : din;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = {adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) state_d = FINISH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FINISH: begin
        bcd_d   = acc_q;
        neg_d   = negr_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      negr_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      negr_q  <= negr_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed corner cases plus a long random run, with a
// cycle-level protocol model and a result scoreboard checked by a monitor.
module tb_bin2bcd_seq;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int BW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WIDTH-1:0] din;
  logic          busy, done, neg;
  logic [BW-1:0] bcd;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy), .done(done), .bcd(bcd), .neg(neg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;
  int cyc = 0;

  // Reference: decimal digits of |din| plus sign, by plain arithmetic.
  function automatic logic [BW:0] ref_conv(input logic [WIDTH-1:0] v);
    int s;
    int m;
    logic [BW-1:0] b;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    b = '0;
    for (int k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {(s < 0), b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol model: accepted starts, busy window, done timing, held outputs.
  logic [BW:0] sb[$];
  int          mcnt = 0;
  bit          mdone = 0;
  logic [BW:0] pend = '0;
  logic [BW:0] mout = '0;

  always @(posedge clk) begin
    cyc++;
    mdone = 0;
    if (rst) begin
      mcnt = 0;
      sb.delete();
      mout = '0;
    end else if (mcnt == 0 && start) begin
      pend = ref_conv(din);
      sb.push_back(pend);
      mcnt = WIDTH + 1;
    end else if (mcnt != 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mdone = 1;
        mout  = pend;
      end
    end
  end

  // Monitor: scoreboard pop on done, plus per-cycle protocol checks.
  int prev_done_cyc = 0;
  int last_done_cyc = 0;
  logic [BW:0] e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", 32'({neg, bcd}), 32'(e));
        end
      end
      chk("busy", 32'(busy), 32'(mcnt != 0));
      chk("done", 32'(done), 32'(mdone));
      chk("held_out", 32'({neg, bcd}), 32'(mout));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (mcnt != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (mcnt != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic go(input logic [WIDTH-1:0] v);
    start = 1'b1;
    din   = v;
    @(posedge clk); #1;
    start = 1'b0;
    din   = WIDTH'($urandom);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed values including both ends of the signed range.
    go(16'h0000);  wait_idle();
    go(16'd12345); wait_idle();
    go(16'hFFFF);  wait_idle();
    go(16'h8000);  wait_idle();
    go(16'h7FFF);  wait_idle();

    // Start while busy is ignored; start in the done cycle is accepted.
    go(16'd999);
    repeat (5) @(posedge clk);
    #1;
    go(16'd555);
    n = 0;
    while (!mdone && n < 40) begin @(posedge clk); #1; n++; end
    go(16'd555);
    wait_idle();
    @(posedge clk); #1;
    chk("b2b_period", 32'(last_done_cyc - prev_done_cyc), 32'(WIDTH + 2));

    // Reset mid-conversion aborts without a done, then a clean retry.
    go(-16'sd42);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    go(-16'sd42);
    wait_idle();

    // Random traffic: frequent start pulses (many ignored), rare resets.
    for (int i = 0; i < 24000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      din   = WIDTH'($urandom);
      rst   = ($urandom_range(0, 1999) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst   = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
